vga_text_console: RTL and testbench

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

---
 rtl/vga_text_pkg.sv | 32 +++
 rtl/vga_text_cursor.sv | 61 ++++++
 rtl/vga_text_console.sv | 200 ++++++++++++++++++++
 tb/tb_vga_text_console.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_text_pkg : shared geometry, control codes and FSM encoding  rev 1.0  |
// +--------------------------------------------------------------------------+
package vga_text_pkg;

   localparam int         COLS  = 40;
   localparam int         ROWS  = 20;
   localparam logic [7:0] BLANK = 8'h20;

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PUT     = 3'd1,
      S_SCR_RD  = 3'd2,
      S_SCR_WR  = 3'd3,
      S_SCR_CLR = 3'd4,
      S_CLR     = 3'd5
   } state_t;

   // Linear cell index; row*cols+col stays below 1024 for legal geometries.
   function automatic logic [9:0] cell_addr(input logic [4:0] y, input logic [5:0] x,
                                            input int cols);
      return 10'(int'(y) * cols + int'(x));
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_text_cursor : cursor register with advance/line-step/backspace rev 1.0|
// +--------------------------------------------------------------------------+
module vga_text_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS = vga_text_pkg::COLS,
   parameter int ROWS = vga_text_pkg::ROWS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   input  logic       newline,
   input  logic       cret,
   input  logic       bksp,
   input  logic       home,
   output logic [5:0] cur_x,
   output logic [4:0] cur_y,
   output logic [5:0] bs_x,
   output logic [4:0] bs_y,
   output logic       bs_ok,
   output logic       scroll_req
);

   logic w_last_col;
   logic w_last_row;
   logic w_step;

   assign w_last_col = (cur_x == 6'(COLS - 1));
   assign w_last_row = (cur_y == 5'(ROWS - 1));
   assign w_step     = newline | (adv & w_last_col);
   // A line step on the bottom row keeps the row and hands off to a scroll.
   assign scroll_req = w_step & w_last_row;

   assign bs_ok = (cur_x != 6'd0) || (cur_y != 5'd0);
   assign bs_x  = (cur_x != 6'd0) ? cur_x - 6'd1 : 6'(COLS - 1);
   assign bs_y  = (cur_x != 6'd0) ? cur_y : cur_y - 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_x <= 6'd0;
         cur_y <= 5'd0;
      end else if (home) begin
         cur_x <= 6'd0;
         cur_y <= 5'd0;
      end else if (bksp && bs_ok) begin
         cur_x <= bs_x;
         cur_y <= bs_y;
      end else if (cret || w_step) begin
         cur_x <= 6'd0;
         if (w_step && !w_last_row) begin
            cur_y <= cur_y + 5'd1;
         end
      end else if (adv) begin
         cur_x <= cur_x + 6'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_text_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_text_console : character stream to text-RAM writer with scroll rev 1.0|
// +--------------------------------------------------------------------------+
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter int         COLS  = vga_text_pkg::COLS,
   parameter int         ROWS  = vga_text_pkg::ROWS,
   parameter logic [7:0] BLANK = vga_text_pkg::BLANK
) (
   input  logic       ram_clk,
   input  logic       rst_n,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic [9:0] addr,
   output logic [7:0] data_in,
   output logic       we,
   input  logic [7:0] data_out,
   output logic [5:0] cur_x,
   output logic [4:0] cur_y,
   output logic       busy
);

   localparam logic [9:0] COLS_W    = 10'(COLS);
   localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
   localparam logic [9:0] COPY_LAST = 10'(COLS * (ROWS - 1) - 1);
   localparam logic [9:0] LAST_ROW  = 10'(COLS * (ROWS - 1));
   localparam logic [9:0] CELL_LAST = 10'(COLS * ROWS - 1);

   state_t     r_state,   w_state_nxt;
   logic [9:0] r_cnt,     w_cnt_nxt;
   logic [9:0] r_addr,    w_addr_nxt;
   logic [7:0] r_data,    w_data_nxt;
   logic       r_we,      w_we_nxt;
   logic       r_put_adv, w_put_adv_nxt;

   logic       w_adv, w_newline, w_cret, w_bksp, w_home;
   logic       w_scroll_req, w_bs_ok;
   logic [5:0] w_bs_x;
   logic [4:0] w_bs_y;

   vga_text_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk        (ram_clk),
      .rst_n      (rst_n),
      .adv        (w_adv),
      .newline    (w_newline),
      .cret       (w_cret),
      .bksp       (w_bksp),
      .home       (w_home),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .bs_x       (w_bs_x),
      .bs_y       (w_bs_y),
      .bs_ok      (w_bs_ok),
      .scroll_req (w_scroll_req)
   );

   always_ff @(posedge ram_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 10'd0;
         r_addr    <= 10'd0;
         r_data    <= 8'd0;
         r_we      <= 1'b0;
         r_put_adv <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_addr    <= w_addr_nxt;
         r_data    <= w_data_nxt;
         r_we      <= w_we_nxt;
         r_put_adv <= w_put_adv_nxt;
      end
   end

   // Bus outputs are registered on entry to each state, so each state's
   // RAM access is visible during the cycle it occupies.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_addr_nxt    = r_addr;
      w_data_nxt    = r_data;
      w_we_nxt      = 1'b0;
      w_put_adv_nxt = r_put_adv;
      w_adv         = 1'b0;
      w_newline     = 1'b0;
      w_cret        = 1'b0;
      w_bksp        = 1'b0;
      w_home        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (char_valid) begin
               case (char_data)
                  CODE_BS: begin
                     if (w_bs_ok) begin
                        w_bksp        = 1'b1;
                        w_state_nxt   = S_PUT;
                        w_we_nxt      = 1'b1;
                        w_addr_nxt    = cell_addr(w_bs_y, w_bs_x, COLS);
                        w_data_nxt    = BLANK;
                        w_put_adv_nxt = 1'b0;
                     end
                  end
                  CODE_LF: begin
                     w_newline = 1'b1;
                     if (w_scroll_req) begin
                        w_state_nxt = S_SCR_RD;
                        w_cnt_nxt   = 10'd0;
                        w_addr_nxt  = COLS_W;
                     end
                  end
                  CODE_CR: begin
                     w_cret = 1'b1;
                  end
                  CODE_FF: begin
                     w_home      = 1'b1;
                     w_state_nxt = S_CLR;
                     w_cnt_nxt   = 10'd0;
                     w_addr_nxt  = 10'd0;
                     w_we_nxt    = 1'b1;
                     w_data_nxt  = BLANK;
                  end
                  default: begin
                     w_state_nxt   = S_PUT;
                     w_we_nxt      = 1'b1;
                     w_addr_nxt    = cell_addr(cur_y, cur_x, COLS);
                     w_data_nxt    = char_data;
                     w_put_adv_nxt = 1'b1;
                  end
               endcase
            end
         end
         S_PUT: begin
            w_state_nxt = S_IDLE;
            if (r_put_adv) begin
               w_adv = 1'b1;
               if (w_scroll_req) begin
                  w_state_nxt = S_SCR_RD;
                  w_cnt_nxt   = 10'd0;
                  w_addr_nxt  = COLS_W;
               end
            end
         end
         S_SCR_RD: begin
            w_state_nxt = S_SCR_WR;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_cnt;
         end
         S_SCR_WR: begin
            if (r_cnt == COPY_LAST) begin
               w_state_nxt = S_SCR_CLR;
               w_cnt_nxt   = 10'd0;
               w_addr_nxt  = LAST_ROW;
               w_we_nxt    = 1'b1;
               w_data_nxt  = BLANK;
            end else begin
               w_state_nxt = S_SCR_RD;
               w_cnt_nxt   = r_cnt + 10'd1;
               w_addr_nxt  = r_cnt + 10'd1 + COLS_W;
            end
         end
         S_SCR_CLR: begin
            if (r_cnt == COL_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt  = r_cnt + 10'd1;
               w_addr_nxt = r_addr + 10'd1;
               w_we_nxt   = 1'b1;
            end
         end
         S_CLR: begin
            if (r_cnt == CELL_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt  = r_cnt + 10'd1;
               w_addr_nxt = r_addr + 10'd1;
               w_we_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign addr       = r_addr;
   assign we         = r_we;
   // The copy writes back what the RAM returns for the read issued one cycle earlier.
   assign data_in    = (r_state == S_SCR_WR) ? data_out : r_data;
   assign busy       = (r_state != S_IDLE);
   assign char_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_text_console : self-checking bench with screen model      rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_vga_text_console;

   localparam int         COLS  = 40;
   localparam int         ROWS  = 20;
   localparam int         CELLS = COLS * ROWS;
   localparam logic [7:0] BLANK = 8'h20;

   typedef struct packed {
      logic       we;
      logic [9:0] addr;
      logic [7:0] data;
   } bus_t;

   logic       ram_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       char_valid = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       char_ready;
   logic [9:0] addr;
   logic [7:0] data_in;
   logic       we;
   logic [7:0] data_out;
   logic [5:0] cur_x;
   logic [4:0] cur_y;
   logic       busy;

   always #5 ram_clk = ~ram_clk;

   vga_text_console #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .BLANK (BLANK)
   ) dut (
      .ram_clk    (ram_clk),
      .rst_n      (rst_n),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .addr       (addr),
      .data_in    (data_in),
      .we         (we),
      .data_out   (data_out),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .busy       (busy)
   );

   // External text RAM, synchronous read.
   logic [7:0] ram [0:1023];
   logic       fill_req = 1'b0;
   always @(posedge ram_clk) begin
      if (fill_req) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'(i);
      end else if (we) begin
         ram[addr] <= data_in;
      end
      data_out <= ram[addr];
   end

   // Screen model: cursor, expected screen contents, expected bus cycles.
   int         mx, my;
   logic [7:0] mram [0:1023];
   bus_t       exp_q [$];
   int         checks = 0;
   int         failures = 0;
   bit         chk_en = 1'b0;
   int         busy_cnt = 0;
   int         wr_cnt = 0;
   logic [9:0] last_addr = 10'd0;
   logic [7:0] last_data = 8'd0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      exp_q.push_back(bus_t'{we: 1'b1, addr: 10'(a), data: d});
      mram[a] = d;
   endtask

   task automatic push_rd(input int a);
      exp_q.push_back(bus_t'{we: 1'b0, addr: 10'(a), data: 8'h00});
   endtask

   task automatic line_step();
      if (my < ROWS - 1) begin
         my++;
      end else begin
         for (int i = 0; i < COLS * (ROWS - 1); i++) begin
            push_rd(i + COLS);
            push_wr(i, mram[i + COLS]);
         end
         for (int i = COLS * (ROWS - 1); i < CELLS; i++) push_wr(i, BLANK);
      end
   endtask

   task automatic model_apply(input logic [7:0] c);
      case (c)
         8'h08: begin
            if (mx > 0) begin
               mx--;
               push_wr(my * COLS + mx, BLANK);
            end else if (my > 0) begin
               my--;
               mx = COLS - 1;
               push_wr(my * COLS + mx, BLANK);
            end
         end
         8'h0A: begin
            mx = 0;
            line_step();
         end
         8'h0D: mx = 0;
         8'h0C: begin
            for (int i = 0; i < CELLS; i++) push_wr(i, BLANK);
            mx = 0;
            my = 0;
         end
         default: begin
            push_wr(my * COLS + mx, c);
            if (mx < COLS - 1) begin
               mx++;
            end else begin
               mx = 0;
               line_step();
            end
         end
      endcase
   endtask

   // Per-cycle compare against the model's expected bus activity.
   initial begin
      bus_t        e;
      logic [31:0] act, want;
      forever begin
         @(negedge ram_clk);
         if (chk_en && rst_n) begin
            if (busy) busy_cnt++;
            if (we) begin
               wr_cnt++;
               last_addr = addr;
               last_data = data_in;
            end
            if (exp_q.size() > 0) begin
               e    = exp_q.pop_front();
               act  = {11'd0, busy, char_ready, we, addr, (we ? data_in : 8'h00)};
               want = {11'd0, 1'b1, 1'b0, e.we, e.addr, (e.we ? e.data : 8'h00)};
               chk(act === want, "bus", act, want);
            end else begin
               act  = {18'd0, busy, char_ready, we, cur_x, cur_y};
               want = {18'd0, 1'b0, 1'b1, 1'b0, 6'(mx), 5'(my)};
               chk(act === want, "idle", act, want);
            end
         end
      end
   end

   task automatic start(input logic [7:0] c);
      char_valid = 1'b1;
      char_data  = c;
      @(posedge ram_clk);
      model_apply(c);
      #1 char_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(negedge ram_clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk(1'b0, "timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge ram_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      start(c);
      wait_idle();
   endtask

   task automatic chk_cur(input string name, input int x, input int y);
      chk({cur_x, cur_y} === {6'(x), 5'(y)}, name, {21'd0, cur_x, cur_y},
          {21'd0, 6'(x), 5'(y)});
   endtask

   task automatic chk_reset_outputs(input string name);
      logic [31:0] act;
      act = {5'd0, busy, char_ready, we, addr, data_in, cur_x[2:0], cur_y[2:0]};
      chk(act === 32'h0200_0000 && cur_x === 6'd0 && cur_y === 5'd0, name, act,
          32'h0200_0000);
   endtask

   initial begin
      int bad;
      mx = 0;
      my = 0;
      for (int i = 0; i < 1024; i++) mram[i] = 8'h00;

      #2;
      chk_reset_outputs("reset_state");
      repeat (2) @(negedge ram_clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge ram_clk);
      #1;

      wr_cnt = 0;
      send(8'h41);
      chk(wr_cnt == 1 && last_addr === 10'd0 && last_data === 8'h41, "put_A",
          {14'd0, last_addr, last_data}, {14'd0, 10'd0, 8'h41});
      chk_cur("cur_A", 1, 0);

      send(8'h0D);
      chk_cur("cr", 0, 0);

      wr_cnt = 0;
      send(8'h08);
      chk(wr_cnt == 0, "bs_origin_nowrite", 32'(wr_cnt), 32'd0);
      chk_cur("bs_origin_cur", 0, 0);

      send(8'h78);
      send(8'h79);
      send(8'h08);
      chk(last_addr === 10'd1 && last_data === BLANK, "bs_mid",
          {14'd0, last_addr, last_data}, {14'd0, 10'd1, BLANK});
      chk_cur("bs_mid_cur", 1, 0);

      wr_cnt = 0;
      send(8'h0C);
      chk(wr_cnt == CELLS, "clear_writes", 32'(wr_cnt), 32'(CELLS));
      chk_cur("clear_cur", 0, 0);

      send(8'h0A);
      send(8'h0A);
      send(8'h08);
      chk(last_addr === 10'd79 && last_data === BLANK, "bs_wrap",
          {14'd0, last_addr, last_data}, {14'd0, 10'd79, BLANK});
      chk_cur("bs_wrap_cur", 39, 1);

      send(8'h0C);
      for (int k = 0; k < 5; k++) send(8'h0A);
      for (int k = 0; k < 39; k++) send(8'h61 + 8'(k % 26));
      busy_cnt = 0;
      send(8'h42);
      chk(last_addr === 10'd239 && last_data === 8'h42, "put_eol",
          {14'd0, last_addr, last_data}, {14'd0, 10'd239, 8'h42});
      chk_cur("put_eol_cur", 0, 6);
      chk(busy_cnt == 1, "put_eol_busy", 32'(busy_cnt), 32'd1);

      send(8'h0C);
      for (int k = 0; k < 19; k++) send(8'h0A);
      for (int k = 0; k < 3; k++) send(8'h61 + 8'(k));
      chk_cur("pre_scroll_cur", 3, 19);
      fill_req = 1'b1;
      @(posedge ram_clk);
      #1 fill_req = 1'b0;
      for (int i = 0; i < 1024; i++) mram[i] = 8'(i);
      busy_cnt = 0;
      send(8'h0A);
      chk(busy_cnt == 1560, "scroll_busy", 32'(busy_cnt), 32'd1560);
      chk(ram[0] === 8'h28, "scroll_ram0", {24'd0, ram[0]}, 32'h28);
      chk(ram[759] === 8'h1F, "scroll_ram759", {24'd0, ram[759]}, 32'h1F);
      chk(ram[760] === BLANK && ram[799] === BLANK, "scroll_lastrow",
          {16'd0, ram[760], ram[799]}, {16'd0, BLANK, BLANK});
      chk_cur("scroll_cur", 0, 19);

      for (int k = 0; k < COLS; k++) send(8'h30 + 8'(k % 10));
      chk_cur("wrap_scroll_cur", 0, 19);

      bad = 0;
      for (int i = 0; i < CELLS; i++) if (ram[i] !== mram[i]) bad++;
      chk(bad == 0, "ram_sweep", 32'(bad), 32'd0);

      start(8'h0A);
      repeat (500) @(posedge ram_clk);
      #2;
      chk(busy === 1'b1, "pre_reset_busy", {31'd0, busy}, 32'd1);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      exp_q.delete();
      mx = 0;
      my = 0;
      repeat (2) @(negedge ram_clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge ram_clk);
      #1;
      chk(char_ready === 1'b1, "ready_after_reset", {31'd0, char_ready}, 32'd1);
      wr_cnt = 0;
      send(8'h5A);
      chk(wr_cnt == 1 && last_addr === 10'd0 && last_data === 8'h5A, "put_Z",
          {14'd0, last_addr, last_data}, {14'd0, 10'd0, 8'h5A});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
